// File: rtl/ge_regmachine_seq.sv
// ge_regmachine_seq: sequential GE program executor.
// Holds a loadable program of {op,dst,src} instructions and runs it one
// instruction per clock over NREG working registers seeded from NIN latched
// inputs. start/done handshake with the fitness harness; prog_* from the loader.
module ge_regmachine_seq #(
  parameter  int W     = 16,
  parameter  int NREG  = 4,
  parameter  int NIN   = 4,
  parameter  int DEPTH = 64,
  localparam int DW    = $clog2(NREG),
  localparam int SW    = $clog2(NREG + NIN),
  localparam int IW    = 3 + DW + SW,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [IW-1:0]        prog_data,
  input  logic [LW-1:0]        prog_len,
  input  logic [NIN*W-1:0]     in_bus,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [NREG*W-1:0]    y_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   mem [DEPTH];
  logic [W-1:0]    r   [NREG];
  logic [W-1:0]    inl [NIN];
  logic [AW-1:0]   pc;
  logic [LW-1:0]   len;

  logic [IW-1:0]   instr;
  logic [2:0]      op;
  logic [DW-1:0]   dst;
  logic [SW-1:0]   src;
  logic [W-1:0]    sval;
  logic [W-1:0]    dval;
  logic [W-1:0]    res;
  logic            last;
  logic [LW-1:0]   len_clamped;

  assign busy  = (state != S_IDLE);
  assign instr = mem[pc];
  assign op    = instr[IW-1 -: 3];
  assign dst   = instr[SW +: DW];
  assign src   = instr[SW-1:0];
  assign last  = (LW'(pc) == (len - LW'(1)));
  assign len_clamped = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;

  // Operand fetch: registers first, then latched inputs, anything beyond reads zero.
  always_comb begin
    sval = '0;
    dval = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(src) == i) sval = r[i];
      if (32'(dst) == i) dval = r[i];
    end
    for (int unsigned j = 0; j < NIN; j++) begin
      if (32'(src) == 32'(NREG) + j) sval = inl[j];
    end
  end

  // ALU: result written back to r[dst]; NOP/reserved keep the destination value.
  always_comb begin
    res = dval;
    unique case (op)
      3'd1:    res = dval ^ sval;
      3'd2:    res = dval | sval;
      3'd3:    res = dval & sval;
      3'd4:    res = {{(W-1){1'b0}}, (sval == '0)};
      3'd5:    res = sval;
      3'd6:    res = ~sval;
      default: res = dval;
    endcase
  end

  // Program memory: writable only while idle; reset fills with NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Run-control FSM with datapath registers, pc and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      len   <= '0;
      done  <= 1'b0;
      y_bus <= '0;
      for (int unsigned i = 0; i < NREG; i++) r[i]   <= '0;
      for (int unsigned j = 0; j < NIN; j++)  inl[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned j = 0; j < NIN; j++) inl[j] <= in_bus[j*W +: W];
            len   <= len_clamped;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            for (int unsigned i = 0; i < NREG; i++) r[i] <= inl[i % NIN];
            pc    <= '0;
            state <= (len == '0) ? S_DONE : S_EXEC;
          end
        end
        S_EXEC: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            r[dst] <= res;
            pc     <= pc + AW'(1);
            if (last) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            for (int unsigned i = 0; i < NREG; i++) y_bus[i*W +: W] <= r[i];
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ge_regmachine_seq.sv
// Directed self-checking bench for ge_regmachine_seq (default parameters).
module tb_ge_regmachine_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [6:0]  prog_len = '0;
  logic [63:0] in_bus = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] y_bus;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IN_A = {16'h0F0F, 16'hAAAA, 16'h00FF, 16'h1234};
  localparam logic [63:0] Y_A  = {16'h1DC4, 16'hAAAA, 16'h00FF, 16'h1234};
  localparam logic [63:0] IN_B = {16'h0001, 16'h5555, 16'h00F0, 16'h000F};
  localparam logic [63:0] Y_B  = {16'h00FE, 16'h5555, 16'h00F0, 16'h000F};
  localparam logic [63:0] IN_C = {16'hCAFE, 16'h0BAD, 16'hBEEF, 16'h7777};

  ge_regmachine_seq #(.W(16), .NREG(4), .NIN(4), .DEPTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .in_bus    (in_bus),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .y_bus     (y_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int op, input int dst, input int src);
    return {3'(op), 2'(dst), 3'(src)};
  endfunction

  task automatic write_word(input int a, input logic [7:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 6'(a);
    prog_data = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  // Counts rising edges until done is seen; lat starts at base edges already elapsed.
  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input logic [63:0] inb, input int len, output int lat);
    @(negedge clk);
    in_bus   = inb;
    prog_len = 7'(len);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat);
  endtask

  initial begin
    int lat;
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_y", y_bus, 64'd0);
    @(negedge clk) rst = 1'b0;

    // XOR chain: r3 ^= r1; r3 ^= r0
    write_word(0, enc(1, 3, 1));
    write_word(1, enc(1, 3, 0));
    run(IN_A, 2, lat);
    chk("xor_lat", 64'(lat), 64'd4);
    chk("xor_done", 64'(done), 64'd1);
    chk("xor_y", y_bus, Y_A);
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'd0);

    // LNOT / BNOT on input 0
    write_word(0, enc(4, 0, 4));
    write_word(1, enc(6, 1, 4));
    run({16'h3333, 16'h2222, 16'h1111, 16'h0000}, 1, lat);
    chk("lnot0_lat", 64'(lat), 64'd3);
    chk("lnot0_y0", 64'(y_bus[15:0]), 64'h0001);
    run({16'h3333, 16'h2222, 16'h1111, 16'h0005}, 2, lat);
    chk("lnot5_y0", 64'(y_bus[15:0]), 64'h0000);
    chk("bnot5_y1", 64'(y_bus[31:16]), 64'hFFFA);

    // Length boundaries: 0 and DEPTH+1 (clamped to DEPTH)
    for (int a = 0; a < 63; a++) write_word(a, 8'h00);
    write_word(63, enc(6, 3, 3));
    run(IN_A, 0, lat);
    chk("len0_lat", 64'(lat), 64'd2);
    chk("len0_y", y_bus, IN_A);
    run(IN_A, 65, lat);
    chk("lenmax_lat", 64'(lat), 64'd66);
    chk("lenmax_y", y_bus, {16'hF0F0, 16'hAAAA, 16'h00FF, 16'h1234});

    // start/prog_we while busy are ignored; back-to-back start in done cycle
    write_word(0, enc(1, 3, 1));
    write_word(1, enc(1, 3, 0));
    @(negedge clk);
    in_bus   = IN_A;
    prog_len = 7'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 6'd0;
    prog_data = enc(6, 3, 3);
    in_bus    = IN_C;
    @(posedge clk);
    #1;
    start   = 1'b0;
    prog_we = 1'b0;
    wait_done(1, lat);
    chk("busyign_lat", 64'(lat), 64'd4);
    chk("busyign_y", y_bus, Y_A);
    chk("b2b_done_hi", 64'(done), 64'd1);
    in_bus = IN_B;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat);
    chk("b2b_lat", 64'(lat), 64'd4);
    chk("b2b_y", y_bus, Y_B);

    // Abort at first EXEC cycle
    @(negedge clk);
    in_bus   = IN_A;
    prog_len = 7'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 abort = 1'b1;
    chk("abort_busy_pre", 64'(busy), 64'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy_post", 64'(busy), 64'd0);
    seen = done;
    repeat (6) begin
      @(posedge clk);
      #1 seen = seen | done;
    end
    chk("abort_nodone", 64'(seen), 64'd0);
    chk("abort_ykeep", y_bus, Y_B);

    // start and abort together in IDLE: start wins
    @(negedge clk);
    in_bus   = IN_A;
    prog_len = 7'd2;
    start    = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    wait_done(0, lat);
    chk("startwins_lat", 64'(lat), 64'd4);
    chk("startwins_y", y_bus, Y_A);

    // Reset mid-EXEC
    @(negedge clk);
    in_bus   = IN_C;
    prog_len = 7'd10;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_y", y_bus, 64'd0);
    @(negedge clk) rst = 1'b0;
    run(IN_C, 0, lat);
    chk("postrst_len0_lat", 64'(lat), 64'd2);
    chk("postrst_len0_y", y_bus, IN_C);
    run(IN_A, 2, lat);
    chk("postrst_memnop_y", y_bus, IN_A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
